net_drop_fifo: RTL

- Store-and-forward packet FIFO at the consuming end of an abortable network stream.
- Accepts the valid/ready/data/last/abort stream and buffers each packet until LAST arrives.
- Discards any packet that is aborted or overflows the buffer.
- Emits only complete, never-aborted packets downstream, so sinks that cannot handle ABORT (DMA writers, CPU packet buffers) can attach after the skid stages.

---
 rtl/net_drop_fifo.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/net_drop_fifo.sv
// -----------------------------------------------------------------------------
// net_drop_fifo
//
// Store-and-forward packet FIFO for the consuming end of an abortable network
// stream. Beats are buffered until LAST arrives; only then is the packet
// committed and made visible to the read side. Packets that are aborted, or
// that do not fit in the remaining buffer space, are discarded entirely, so
// the downstream sink never sees ABORT or a partial packet.
//
// Parameters:
//   DW      data width in bits
//   LGFLEN  log2 of the buffer depth in words (minimum 1, i.e. depth 2)
//
// Ports:
//   S_AXI_ACLK       clock
//   S_AXI_ARESETN    synchronous active-low reset
//   S_AXIN_*         inbound stream (VALID/READY/DATA/LAST/ABORT); READY is 1
//                    whenever the block is out of reset (never backpressures)
//   M_AXIN_*         outbound stream (VALID/READY/DATA/LAST/ABORT); ABORT is 0
//   o_fill           committed words not yet loaded into the output stage
//
// Optional feature (macro NET_DROP_FIFO_STATS_EN):
//   o_abort_count    aborts of a packet in progress (FILL or DROP)
//   o_overflow_count beats that found the buffer full and dropped the packet
//   o_pkt_count      packets committed
//   All three are 16-bit, saturating, cleared by reset.
// -----------------------------------------------------------------------------
module net_drop_fifo #(
    parameter int DW     = 32,
    parameter int LGFLEN = 9
) (
    input  logic              S_AXI_ACLK,
    input  logic              S_AXI_ARESETN,

    input  logic              S_AXIN_VALID,
    output logic              S_AXIN_READY,
    input  logic [DW-1:0]     S_AXIN_DATA,
    input  logic              S_AXIN_LAST,
    input  logic              S_AXIN_ABORT,

    output logic              M_AXIN_VALID,
    input  logic              M_AXIN_READY,
    output logic [DW-1:0]     M_AXIN_DATA,
    output logic              M_AXIN_LAST,
    output logic              M_AXIN_ABORT,

`ifdef NET_DROP_FIFO_STATS_EN
    output logic [15:0]       o_abort_count,
    output logic [15:0]       o_overflow_count,
    output logic [15:0]       o_pkt_count,
`endif
    output logic [LGFLEN:0]   o_fill
);

    typedef enum logic [1:0] {
        IDLE,   // no partial packet in the buffer
        FILL,   // partial packet being written
        DROP    // discarding the rest of an overflowed packet
    } wr_state_t;

    // Pointers carry one extra bit so that full (difference == depth) and
    // empty (difference == 0) are distinguishable.
    localparam logic [LGFLEN:0] PTR_ONE  = {{LGFLEN{1'b0}}, 1'b1};
    localparam logic [LGFLEN:0] FULL_LVL = {1'b1, {LGFLEN{1'b0}}};

    wr_state_t        state;
    logic [LGFLEN:0]  wr_addr;
    logic [LGFLEN:0]  commit_addr;
    logic [LGFLEN:0]  rd_addr;

    logic [DW:0]      mem [0:(1<<LGFLEN)-1];

    logic             abort_pkt;
    logic             beat;
    logic             full;
    logic             mem_we;
    logic             overflow;
    logic             rd_load;

    // -------------------------------------------------------------------------
    // Write-side decode
    // -------------------------------------------------------------------------
    // An ABORT only matters while a packet is in progress; in IDLE it merely
    // suppresses a beat presented in the same cycle.
    assign abort_pkt = S_AXIN_ABORT && (state != IDLE);
    assign beat      = S_AXIN_VALID && !S_AXIN_ABORT;
    // Full is judged against rd_addr, which only moves when a committed word
    // is loaded into the output stage, so uncommitted data is never overrun.
    assign full      = (wr_addr - rd_addr) == FULL_LVL;
    assign mem_we    = beat && (state != DROP) && !full;
    assign overflow  = beat && (state != DROP) && full;

    assign S_AXIN_READY = S_AXI_ARESETN;
    assign M_AXIN_ABORT = 1'b0;

    // -------------------------------------------------------------------------
    // Write-side state and pointers
    // -------------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every branch below sees the pre-edge values of wr_addr/commit_addr.
    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            state       <= IDLE;
            wr_addr     <= '0;
            commit_addr <= '0;
        end else if (abort_pkt) begin
            // Rewind over the partial packet; any beat this cycle is lost.
            wr_addr <= commit_addr;
            state   <= IDLE;
        end else if (mem_we) begin
            wr_addr <= wr_addr + PTR_ONE;
            if (S_AXIN_LAST) begin
                commit_addr <= wr_addr + PTR_ONE;
                state       <= IDLE;
            end else begin
                state <= FILL;
            end
        end else if (overflow) begin
            // Packet cannot fit: rewind and swallow the rest of it.
            wr_addr <= commit_addr;
            state   <= S_AXIN_LAST ? IDLE : DROP;
        end else if (beat && (state == DROP) && S_AXIN_LAST) begin
            state <= IDLE;
        end
    end

    // NOTE: the packet memory is deliberately not reset; the pointers define
    // which entries are meaningful, and a reset-free array maps onto block RAM.
    always_ff @(posedge S_AXI_ACLK) begin
        if (mem_we) begin
            mem[wr_addr[LGFLEN-1:0]] <= {S_AXIN_LAST, S_AXIN_DATA};
        end
    end

    // -------------------------------------------------------------------------
    // Read side: registered output stage
    // -------------------------------------------------------------------------
    // Load a new word whenever committed data exists and the output register
    // is empty or being consumed this cycle; otherwise hold while stalled.
    assign rd_load = (rd_addr != commit_addr) && (!M_AXIN_VALID || M_AXIN_READY);

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            rd_addr      <= '0;
            M_AXIN_VALID <= 1'b0;
            M_AXIN_LAST  <= 1'b0;
            M_AXIN_DATA  <= '0;
        end else if (rd_load) begin
            {M_AXIN_LAST, M_AXIN_DATA} <= mem[rd_addr[LGFLEN-1:0]];
            rd_addr      <= rd_addr + PTR_ONE;
            M_AXIN_VALID <= 1'b1;
        end else if (M_AXIN_READY) begin
            M_AXIN_VALID <= 1'b0;
        end
    end

    assign o_fill = commit_addr - rd_addr;

`ifdef NET_DROP_FIFO_STATS_EN
    // -------------------------------------------------------------------------
    // Saturating event counters
    // -------------------------------------------------------------------------
    logic commit_evt;
    assign commit_evt = mem_we && S_AXIN_LAST;

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            o_abort_count    <= '0;
            o_overflow_count <= '0;
            o_pkt_count      <= '0;
        end else begin
            if (abort_pkt && (o_abort_count != 16'hFFFF)) begin
                o_abort_count <= o_abort_count + 16'd1;
            end
            // overflow is already masked by !abort via beat
            if (overflow && !abort_pkt && (o_overflow_count != 16'hFFFF)) begin
                o_overflow_count <= o_overflow_count + 16'd1;
            end
            if (commit_evt && !abort_pkt && (o_pkt_count != 16'hFFFF)) begin
                o_pkt_count <= o_pkt_count + 16'd1;
            end
        end
    end
`endif

endmodule
